// File: rtl/param_bus_datapath.sv
// param_bus_datapath: single-bus datapath (register file, Y, Zhigh/Zlow, ALU,
// HI/LO) with a built-in T-state sequencer. One start pulse runs one complete
// Ra <- Rb op Rc/imm operation: IDLE -> T_Y -> T_ALU -> T_WB [-> T_WB2] -> IDLE.
// Optional feature macro: PARAM_BUS_DATAPATH_FLAGS_EN enables the {C,N,Z} flags.
module param_bus_datapath #(
   parameter int WIDTH  = 32,
   parameter int NREGS  = 16,
   parameter int RSEL_W = 4,
   parameter int SH_W   = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [3:0]        op,
   input  logic [RSEL_W-1:0] ra,
   input  logic [RSEL_W-1:0] rb,
   input  logic [RSEL_W-1:0] rc,
   input  logic [WIDTH-1:0]  imm,
   output logic              busy,
   output logic              done,
   output logic [WIDTH-1:0]  hi,
   output logic [WIDTH-1:0]  lo,
   output logic [2:0]        flags,
   input  logic [RSEL_W-1:0] dbg_sel,
   output logic [WIDTH-1:0]  dbg_data
);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_SHL  = 4'd4;
   localparam logic [3:0] OP_SHR  = 4'd5;
   localparam logic [3:0] OP_ADDI = 4'd6;
   localparam logic [3:0] OP_MUL  = 4'd7;
   localparam logic [3:0] OP_MFHI = 4'd8;
   localparam logic [3:0] OP_MFLO = 4'd9;

   typedef enum logic [2:0] {IDLE, T_Y, T_ALU, T_WB, T_WB2} state_t;

   state_t state, state_nx;

   logic [NREGS-1:0][WIDTH-1:0] regs;
   logic [WIDTH-1:0]  y, zlo, zhi, hi_q, lo_q;
   logic [3:0]        op_q;
   logic [RSEL_W-1:0] ra_q, rb_q, rc_q;
   logic [WIDTH-1:0]  imm_q;
   logic              done_q;

   logic [WIDTH-1:0]  rb_val, rc_val, bus_y, bus_b, alu_lo, alu_hi;
   logic [2*WIDTH-1:0] prod;
   logic              wr_en;
`ifdef PARAM_BUS_DATAPATH_FLAGS_EN
   logic              alu_c, zc;
   logic [2:0]        flags_q;
`endif

   assign busy = (state != IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;
`ifdef PARAM_BUS_DATAPATH_FLAGS_EN
   assign flags = flags_q;
`else
   assign flags = 3'b000;
`endif

   // Register-file read ports; selects at or beyond NREGS match nothing and read 0.
   always_comb begin
      rb_val   = '0;
      rc_val   = '0;
      dbg_data = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (rb_q == i[RSEL_W-1:0])    rb_val   = regs[i];
         if (rc_q == i[RSEL_W-1:0])    rc_val   = regs[i];
         if (dbg_sel == i[RSEL_W-1:0]) dbg_data = regs[i];
      end
   end

   // Bus sources: ADDI with rb==0 uses a zero base, and takes imm in T_ALU.
   always_comb begin
      bus_y = (op_q == OP_ADDI && rb_q == '0) ? '0 : rb_val;
      bus_b = (op_q == OP_ADDI) ? imm_q : rc_val;
   end

   // ALU: computes {Zhigh,Zlow} from Y and the T_ALU bus value.
   always_comb begin
      alu_lo = '0;
      alu_hi = '0;
      prod   = {{WIDTH{1'b0}}, y} * {{WIDTH{1'b0}}, bus_b};
`ifdef PARAM_BUS_DATAPATH_FLAGS_EN
      alu_c  = 1'b0;
`endif
      case (op_q)
         OP_ADD, OP_ADDI: begin
`ifdef PARAM_BUS_DATAPATH_FLAGS_EN
            {alu_c, alu_lo} = {1'b0, y} + {1'b0, bus_b};
`else
            alu_lo = y + bus_b;
`endif
         end
         OP_SUB: begin
`ifdef PARAM_BUS_DATAPATH_FLAGS_EN
            // Carry out of y + ~b + 1 is the inverted borrow.
            {alu_c, alu_lo} = {1'b0, y} + {1'b0, ~bus_b} + {{WIDTH{1'b0}}, 1'b1};
`else
            alu_lo = y - bus_b;
`endif
         end
         OP_AND:  alu_lo = y & bus_b;
         OP_OR:   alu_lo = y | bus_b;
         OP_SHL:  alu_lo = y << bus_b[SH_W-1:0];
         OP_SHR:  alu_lo = y >> bus_b[SH_W-1:0];
         OP_MUL:  {alu_hi, alu_lo} = prod;
         OP_MFHI: alu_lo = hi_q;
         OP_MFLO: alu_lo = lo_q;
         default: alu_lo = '0;
      endcase
   end

   // Ops 0-6, MFHI and MFLO write R[ra]; MUL goes to HI/LO, NOPs write nothing.
   assign wr_en = (op_q <= OP_MFLO) && (op_q != OP_MUL);

   // Sequencer state register.
   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // Sequencer next-state logic; start is only looked at in IDLE.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = T_Y;
         T_Y:     state_nx = T_ALU;
         T_ALU:   state_nx = T_WB;
         T_WB:    state_nx = (op_q == OP_MUL) ? T_WB2 : IDLE;
         T_WB2:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Datapath registers, write-back and the registered done pulse.
   always_ff @(posedge clk) begin
      if (!reset) begin
         regs   <= '0;
         y      <= '0;
         zlo    <= '0;
         zhi    <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         op_q   <= '0;
         ra_q   <= '0;
         rb_q   <= '0;
         rc_q   <= '0;
         imm_q  <= '0;
         done_q <= 1'b0;
`ifdef PARAM_BUS_DATAPATH_FLAGS_EN
         zc      <= 1'b0;
         flags_q <= 3'b000;
`endif
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  op_q  <= op;
                  ra_q  <= ra;
                  rb_q  <= rb;
                  rc_q  <= rc;
                  imm_q <= imm;
               end
            end
            T_Y: y <= bus_y;
            T_ALU: begin
               zlo <= alu_lo;
               zhi <= alu_hi;
`ifdef PARAM_BUS_DATAPATH_FLAGS_EN
               zc  <= alu_c;
`endif
            end
            T_WB: begin
               if (op_q == OP_MUL) begin
                  lo_q <= zlo;
               end else begin
                  done_q <= 1'b1;
                  if (wr_en)
                     for (int i = 0; i < NREGS; i++)
                        if (ra_q == i[RSEL_W-1:0]) regs[i] <= zlo;
`ifdef PARAM_BUS_DATAPATH_FLAGS_EN
                  if (op_q <= OP_ADDI)
                     flags_q <= {zc, zlo[WIDTH-1], (zlo == '0)};
`endif
               end
            end
            T_WB2: begin
               hi_q   <= zhi;
               done_q <= 1'b1;
`ifdef PARAM_BUS_DATAPATH_FLAGS_EN
               flags_q <= {1'b0, zhi[WIDTH-1], ({zhi, zlo} == '0)};
`endif
            end
            default: ;
         endcase
      end
   end

endmodule
